// File: rtl/jzjpcc_pipeline_control.sv
// Central stall/flush sequencer for the 5-stage jzjpcc pipeline.
// Merges load-use hazards, execute-stage redirects and multi-cycle data-memory
// accesses into per-stage stall/flush lines. A small FSM tracks memory waits
// and latches a sticky fault if an access never completes.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   rs1Addr_decode/rs2Addr_decode   source registers of the decode instruction
//   rdAddr_execute, isLoad_execute, rdWriteEnable_execute   execute instruction info
//   branchTaken_execute      redirect resolved in execute this cycle
//   memRequest_memory, memAck_memory   data-memory handshake of memory stage
//   stall_*                  hold the corresponding pipeline register
//   flush_*                  load a bubble into the corresponding register
//   memFault                 sticky memory timeout indication
//   stallCycles, flushEvents performance counters (JZJPCC_PIPELINE_PERF_EN only)
//
// Optional feature macro: JZJPCC_PIPELINE_PERF_EN adds the two perf counters.
module jzjpcc_pipeline_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs1Addr_decode,
  input  logic [4:0]  rs2Addr_decode,
  input  logic [4:0]  rdAddr_execute,
  input  logic        isLoad_execute,
  input  logic        rdWriteEnable_execute,
  input  logic        branchTaken_execute,
  input  logic        memRequest_memory,
  input  logic        memAck_memory,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        stall_memory,
  output logic        flush_decode,
  output logic        flush_execute,
  output logic        flush_writeback,
`ifdef JZJPCC_PIPELINE_PERF_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushEvents,
`endif
  output logic        memFault
);

  typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mem_busy;

  // x0 is hardwired zero, so a load targeting it creates no dependency.
  assign load_use = isLoad_execute & rdWriteEnable_execute & (rdAddr_execute != 5'd0) &
                    ((rdAddr_execute == rs1Addr_decode) | (rdAddr_execute == rs2Addr_decode));
  assign mem_busy = memRequest_memory & ~memAck_memory;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    stall_execute   = 1'b0;
    stall_memory    = 1'b0;
    flush_decode    = 1'b0;
    flush_execute   = 1'b0;
    flush_writeback = 1'b0;
    memFault        = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          // Freeze everything up to memory; writeback gets bubbles meanwhile.
          {stall_fetch, stall_decode, stall_execute, stall_memory} = 4'b1111;
          flush_writeback = 1'b1;
          state_d         = StMemWait;
          cnt_d           = CNT_W'(1);
        end else if (branchTaken_execute) begin
          // Flushing decode kills any dependent instruction, so no load-use stall.
          flush_decode  = 1'b1;
          flush_execute = 1'b1;
        end else if (load_use) begin
          stall_fetch   = 1'b1;
          stall_decode  = 1'b1;
          flush_execute = 1'b1;
        end
      end
      StMemWait: begin
        if (memAck_memory) begin
          // Pipeline releases on this edge; hazards are re-evaluated in RUN.
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          {stall_fetch, stall_decode, stall_execute, stall_memory} = 4'b1111;
          flush_writeback = 1'b1;
          if (cnt_q == TimeoutCnt) begin
            state_d = StFault;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFault: begin
        {stall_fetch, stall_decode, stall_execute, stall_memory} = 4'b1111;
        flush_writeback = 1'b1;
        memFault        = 1'b1;
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef JZJPCC_PIPELINE_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_fetch) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_decode) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushEvents = flush_events_q;
`endif

endmodule
